// File: rtl/riscv_pipe_pkg.sv
// Shared types and constants for the RISC-V pipeline hazard controller.
// Register-match helper treats x0 as never carrying a dependency.
package riscv_pipe_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    ERROR
  } hazard_state_t;

  function automatic logic reg_match(
    input logic                  uses,
    input logic [REG_ADDR_W-1:0] src,
    input logic [REG_ADDR_W-1:0] rd
  );
    return uses && (src == rd) && (rd != REG_ZERO);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low reset.
// Increments on inc_i and holds once it reaches all-ones.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline enable/flush controller: load-use bubbles, redirect flushes, and
// whole-pipe freeze while data memory is busy, with a sticky timeout error.
module pipeline_hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_uses_rs1_i,
  input  logic                  id_uses_rs2_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  ex_mem_read_i,
  input  logic                  ex_redirect_i,
  input  logic                  mem_access_i,
  input  logic                  mem_ready_i,
  output logic                  pc_enable_o,
  output logic                  ifid_enable_o,
  output logic                  ifid_flush_o,
  output logic                  idex_enable_o,
  output logic                  idex_flush_o,
  output logic                  exmem_enable_o,
  output logic                  exmem_flush_o,
  output logic                  memwb_enable_o,
  output logic                  memwb_flush_o,
  output logic                  mem_timeout_o,
  output logic [CNT_WIDTH-1:0]  stall_cycles_o
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  hazard_state_t     state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_timeout_q;

  logic mem_hold;
  logic load_use;
  logic freeze;

  assign mem_hold = mem_access_i & ~mem_ready_i;
  assign load_use = ex_mem_read_i &
                    (reg_match(id_uses_rs1_i, id_rs1_i, ex_rd_i) |
                     reg_match(id_uses_rs2_i, id_rs2_i, ex_rd_i));
  assign freeze   = (state_q == ERROR) | mem_hold;

  // Output decode, priority: reset > freeze > redirect > load-use.
  always_comb begin
    pc_enable_o    = 1'b1;
    ifid_enable_o  = 1'b1;
    ifid_flush_o   = 1'b0;
    idex_enable_o  = 1'b1;
    idex_flush_o   = 1'b0;
    exmem_enable_o = 1'b1;
    exmem_flush_o  = 1'b0;
    memwb_enable_o = 1'b1;
    memwb_flush_o  = 1'b0;
    if (!reset_i) begin
      pc_enable_o    = 1'b0;
      ifid_enable_o  = 1'b0;
      ifid_flush_o   = 1'b1;
      idex_enable_o  = 1'b0;
      idex_flush_o   = 1'b1;
      exmem_enable_o = 1'b0;
      exmem_flush_o  = 1'b1;
      memwb_enable_o = 1'b0;
      memwb_flush_o  = 1'b1;
    end else if (freeze) begin
      pc_enable_o    = 1'b0;
      ifid_enable_o  = 1'b0;
      idex_enable_o  = 1'b0;
      exmem_enable_o = 1'b0;
      memwb_flush_o  = 1'b1;
    end else if (ex_redirect_i) begin
      ifid_flush_o   = 1'b1;
      idex_flush_o   = 1'b1;
    end else if (load_use) begin
      pc_enable_o    = 1'b0;
      ifid_enable_o  = 1'b0;
      idex_flush_o   = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      RUN: begin
        if (mem_hold) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = '0;
        end
      end
      MEM_WAIT: begin
        if (!mem_hold) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d    = ERROR;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      ERROR:   state_d = ERROR;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_q | (state_d == ERROR);
    end
  end

  assign mem_timeout_o = mem_timeout_q;

  sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_stall_cnt (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .inc_i  (~pc_enable_o),
    .count_o(stall_cycles_o)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (default and small parameters)
// share stimulus and are compared each cycle against a rule-level model.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       uses1 = 1'b0, uses2 = 1'b0, ex_mem_read = 1'b0, ex_redirect = 1'b0;
  logic       mem_access = 1'b0, mem_ready = 1'b0;

  logic [8:0]  ctl_a, ctl_b;
  logic        tout_a, tout_b;
  logic [31:0] stall_a;
  logic [2:0]  stall_b;

  int          n_tests = 0;
  int          n_fail  = 0;

  int          hold_run [2];
  bit          timed_out[2];
  longint      stall    [2];
  int          tmo      [2] = '{16, 4};
  longint      smax     [2] = '{64'hFFFF_FFFF, 64'd7};

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_WIDTH(32)) dut_a (
    .clk_i(clk), .reset_i(rst),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_uses_rs1_i(uses1), .id_uses_rs2_i(uses2),
    .ex_rd_i(ex_rd), .ex_mem_read_i(ex_mem_read), .ex_redirect_i(ex_redirect),
    .mem_access_i(mem_access), .mem_ready_i(mem_ready),
    .pc_enable_o(ctl_a[8]), .ifid_enable_o(ctl_a[7]), .ifid_flush_o(ctl_a[6]),
    .idex_enable_o(ctl_a[5]), .idex_flush_o(ctl_a[4]),
    .exmem_enable_o(ctl_a[3]), .exmem_flush_o(ctl_a[2]),
    .memwb_enable_o(ctl_a[1]), .memwb_flush_o(ctl_a[0]),
    .mem_timeout_o(tout_a), .stall_cycles_o(stall_a)
  );

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_WIDTH(3)) dut_b (
    .clk_i(clk), .reset_i(rst),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_uses_rs1_i(uses1), .id_uses_rs2_i(uses2),
    .ex_rd_i(ex_rd), .ex_mem_read_i(ex_mem_read), .ex_redirect_i(ex_redirect),
    .mem_access_i(mem_access), .mem_ready_i(mem_ready),
    .pc_enable_o(ctl_b[8]), .ifid_enable_o(ctl_b[7]), .ifid_flush_o(ctl_b[6]),
    .idex_enable_o(ctl_b[5]), .idex_flush_o(ctl_b[4]),
    .exmem_enable_o(ctl_b[3]), .exmem_flush_o(ctl_b[2]),
    .memwb_enable_o(ctl_b[1]), .memwb_flush_o(ctl_b[0]),
    .mem_timeout_o(tout_b), .stall_cycles_o(stall_b)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Control vector {pc_en, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, exmem_fl, memwb_en, memwb_fl}
  function automatic logic [8:0] exp_ctl(input int i);
    bit hold, lu;
    hold = mem_access && !mem_ready;
    lu   = ex_mem_read && (ex_rd != 0) &&
           ((uses1 && id_rs1 == ex_rd) || (uses2 && id_rs2 == ex_rd));
    if (!rst)                   return 9'b0_01_01_01_01;
    if (timed_out[i] || hold)   return 9'b0_00_00_00_11;
    if (ex_redirect)            return 9'b1_11_11_10_10;
    if (lu)                     return 9'b0_00_11_10_10;
    return 9'b1_10_10_10_10;
  endfunction

  // Check current cycle, then advance the model across the coming rising edge.
  task automatic step();
    logic [8:0] e;
    #1;
    chk("A.ctl",     ctl_a,   exp_ctl(0));
    chk("B.ctl",     ctl_b,   exp_ctl(1));
    chk("A.timeout", tout_a,  timed_out[0]);
    chk("B.timeout", tout_b,  timed_out[1]);
    chk("A.stall",   stall_a, stall[0]);
    chk("B.stall",   stall_b, stall[1]);
    for (int i = 0; i < 2; i++) begin
      e = exp_ctl(i);
      if (!rst) begin
        hold_run[i]  = 0;
        timed_out[i] = 1'b0;
        stall[i]     = 0;
      end else begin
        if (!e[8] && stall[i] < smax[i]) stall[i]++;
        // Entry cycle plus MEM_TIMEOUT waiting cycles of unbroken hold -> error
        if (mem_access && !mem_ready) hold_run[i]++;
        else hold_run[i] = 0;
        if (hold_run[i] >= tmo[i] + 1) timed_out[i] = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic drive(input bit r, input logic [4:0] rs1, input logic [4:0] rs2,
                       input bit u1, input bit u2, input logic [4:0] rd,
                       input bit mr, input bit rdr, input bit acc, input bit rdy);
    rst = r; id_rs1 = rs1; id_rs2 = rs2; uses1 = u1; uses2 = u2;
    ex_rd = rd; ex_mem_read = mr; ex_redirect = rdr; mem_access = acc; mem_ready = rdy;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      hold_run[i] = 0; timed_out[i] = 1'b0; stall[i] = 0;
    end
    @(negedge clk);

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step(); step();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();

    drive(1, 5, 0, 1, 0, 5, 1, 0, 0, 0); step();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();

    drive(1, 5, 0, 1, 0, 0, 1, 0, 0, 0); step();
    drive(1, 5, 0, 1, 0, 5, 1, 1, 0, 0); step();
    drive(1, 0, 7, 0, 1, 7, 1, 0, 0, 0); step();

    repeat (3) begin drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0); step(); end
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1); step();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();

    repeat (20) begin drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0); step(); end
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1); step();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();

    repeat (9) begin drive(1, 3, 0, 1, 0, 3, 1, 0, 0, 0); step(); end
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    repeat (2) begin drive(1, 3, 0, 1, 0, 3, 1, 1, 1, 0); step(); end
    drive(1, 3, 0, 1, 0, 3, 1, 1, 1, 1); step();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();

    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 99) != 0,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), $urandom_range(0, 4) == 0,
            $urandom_range(0, 9) < 6, $urandom_range(0, 3) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
